// File: rtl/hamming_enc_seq_if.sv
// -----------------------------------------------------------------------------
// hamming_enc_seq_if
//   Data-memory port between the Hamming encode sequencer and the core-side
//   arbiter/memory.
//
//   mem_req      master -> slave  port request, held for every access state
//   mem_gnt      slave  -> master port granted this cycle
//   mem_addr     master -> slave  byte address
//   mem_wr_en    master -> slave  write strobe, only ever high with mem_gnt
//   mem_wr_data  master -> slave  write byte
//   mem_rd_data  slave  -> master combinational read data for mem_addr
// -----------------------------------------------------------------------------
interface hamming_enc_seq_if #(
  parameter int AW = 8
);
  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [7:0]    mem_rd_data;

  modport master (
    output mem_req, mem_addr, mem_wr_en, mem_wr_data,
    input  mem_gnt, mem_rd_data
  );

  modport slave (
    input  mem_req, mem_addr, mem_wr_en, mem_wr_data,
    output mem_gnt, mem_rd_data
  );
endinterface

// File: rtl/hamming_enc_seq.sv
// -----------------------------------------------------------------------------
// hamming_enc_seq
//   Sequencer that borrows the data-memory port to SECDED-encode NUM_MSG
//   11-bit messages. Each message is read as a byte pair (lo = d[8:1],
//   hi[2:0] = d[11:9]) from SRC_BASE + 2*i and its 16-bit codeword is written
//   as a byte pair to DST_BASE + 2*i. Four granted accesses per message.
//
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   start    single-cycle run request, honoured only in IDLE or DONE
//   busy     high while a run is in progress
//   done     high in DONE until the next start or reset
//   msg_idx  index of the message in flight
//   mem      memory port (master side)
// -----------------------------------------------------------------------------
module hamming_enc_seq #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            msg_idx,
  hamming_enc_seq_if.master     mem
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_MSG - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:1] d_q, d_d;

  // Byte offset of the current pair; wraps modulo 2^AW with the bases.
  logic [AW-1:0] pair_off;
  logic [AW-1:0] src_lo_addr;
  logic [AW-1:0] dst_lo_addr;

  assign pair_off    = AW'({idx_q, 1'b0});
  assign src_lo_addr = AW'(SRC_BASE) + pair_off;
  assign dst_lo_addr = AW'(DST_BASE) + pair_off;

  // Codeword is purely combinational from the latched message.
  logic        p8, p4, p2, p1, p0;
  logic [15:0] cw;

  assign p8 = ^d_q[11:5];
  assign p4 = (^d_q[11:8]) ^ (^d_q[4:2]);
  assign p2 = d_q[11] ^ d_q[10] ^ d_q[7] ^ d_q[6] ^ d_q[4] ^ d_q[3] ^ d_q[1];
  assign p1 = d_q[11] ^ d_q[9]  ^ d_q[7] ^ d_q[5] ^ d_q[4] ^ d_q[2] ^ d_q[1];
  // Overall parity covers data and all Hamming parity bits (SECDED).
  assign p0 = (^d_q) ^ p8 ^ p4 ^ p2 ^ p1;
  assign cw = {d_q[11:5], p8, d_q[4:2], p4, d_q[1], p2, p1, p0};

  // Only three bits of the high message byte carry data.
  logic unused_rd_bits;
  assign unused_rd_bits = ^mem.mem_rd_data[7:3];

  // NOTE: state uses non-blocking assignments so every flop updates from
  // pre-edge values; the datapath registers are cleared too so a reset
  // mid-run leaves no stale message behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case statement can infer a latch.
    state_d         = state_q;
    idx_d           = idx_q;
    d_d             = d_q;
    busy            = 1'b0;
    done            = 1'b0;
    mem.mem_req     = 1'b0;
    mem.mem_addr    = '0;
    mem.mem_wr_en   = 1'b0;
    mem.mem_wr_data = '0;

    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          state_d = RD_LO;
          idx_d   = '0;
        end
      end

      RD_LO: begin
        busy         = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = src_lo_addr;
        if (mem.mem_gnt) begin
          d_d[8:1] = mem.mem_rd_data;
          state_d  = RD_HI;
        end
      end

      RD_HI: begin
        busy         = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = src_lo_addr + AW'(1);
        if (mem.mem_gnt) begin
          d_d[11:9] = mem.mem_rd_data[2:0];
          state_d   = WR_LO;
        end
      end

      WR_LO: begin
        busy            = 1'b1;
        mem.mem_req     = 1'b1;
        mem.mem_addr    = dst_lo_addr;
        mem.mem_wr_data = cw[7:0];
        mem.mem_wr_en   = mem.mem_gnt;
        if (mem.mem_gnt) state_d = WR_HI;
      end

      WR_HI: begin
        busy            = 1'b1;
        mem.mem_req     = 1'b1;
        mem.mem_addr    = dst_lo_addr + AW'(1);
        mem.mem_wr_data = cw[15:8];
        mem.mem_wr_en   = mem.mem_gnt;
        if (mem.mem_gnt) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = RD_LO;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign msg_idx = idx_q;

endmodule

// File: tb/tb_hamming_enc_seq.sv
// -----------------------------------------------------------------------------
// tb_hamming_enc_seq
//   Bench for hamming_enc_seq with default parameters. A byte memory answers
//   the sequencer's port; a transaction-level model (access number k ->
//   message k/4, access kind k%4) predicts every cycle's port activity, and
//   the codeword comes from a generic Hamming(15,11)+overall-parity encoder.
// -----------------------------------------------------------------------------
module tb_hamming_enc_seq;

  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 0;
  localparam int DST_BASE = 30;
  localparam int AW       = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [3:0] msg_idx;

  hamming_enc_seq_if #(.AW(AW)) mem_if ();

  hamming_enc_seq #(
    .NUM_MSG (NUM_MSG),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE),
    .AW      (AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .msg_idx(msg_idx),
    .mem    (mem_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Generic SECDED encoder: data fills non-power-of-two positions 1..15,
  // parity bit 2^b covers positions with bit b set, bit 0 is overall parity.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & (1 << b)) != 0) par ^= c[pos];
      c[1 << b] = par;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Memory: DUT writes and bench preload writes share one process.
  bit   [7:0]    mem [256];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [7:0]    tb_data = '0;

  assign mem_if.mem_rd_data = mem[mem_if.mem_addr];

  always @(posedge clk) begin
    if (mem_if.mem_wr_en) mem[mem_if.mem_addr] <= mem_if.mem_wr_data;
    else if (tb_we)       mem[tb_addr] <= tb_data;
  end

  task automatic mem_write(input int a, input logic [7:0] v);
    tb_we   = 1'b1;
    tb_addr = AW'(a);
    tb_data = v;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  // Grant driver: held high, or pseudo-random when gnt_rand is set.
  bit gnt_rand = 1'b0;
  initial begin
    mem_if.mem_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mem_if.mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Transaction-level model of the run.
  bit         running = 1'b0;
  bit         mdone = 1'b0;
  int         k = 0;
  logic [3:0] midx = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      mdone   <= 1'b0;
      k       <= 0;
      midx    <= '0;
    end else if (!running) begin
      if (start) begin
        running <= 1'b1;
        mdone   <= 1'b0;
        k       <= 0;
        midx    <= '0;
      end
    end else if (mem_if.mem_gnt) begin
      if (k == 4 * NUM_MSG - 1) begin
        running <= 1'b0;
        mdone   <= 1'b1;
      end else begin
        k    <= k + 1;
        midx <= 4'((k + 1) / 4);
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    int            m, ph;
    logic [AW-1:0] ea;
    logic [15:0]   ecw;
    m  = k / 4;
    ph = k % 4;
    if (running) begin
      ea  = (ph < 2) ? AW'(SRC_BASE + 2 * m + ph) : AW'(DST_BASE + 2 * m + ph - 2);
      ecw = encode({mem[SRC_BASE + 2 * m + 1][2:0], mem[SRC_BASE + 2 * m]});
      check("run_req",  mem_if.mem_req, 1);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_idx",  msg_idx, midx);
      check("run_addr", mem_if.mem_addr, ea);
      check("run_wren", mem_if.mem_wr_en, (ph >= 2) && mem_if.mem_gnt);
      if (ph == 2) check("wr_lo_data", mem_if.mem_wr_data, ecw[7:0]);
      if (ph == 3) check("wr_hi_data", mem_if.mem_wr_data, ecw[15:8]);
    end else begin
      check("idle_busy", busy, 0);
      check("idle_req",  mem_if.mem_req, 0);
      check("idle_wren", mem_if.mem_wr_en, 0);
      check("idle_done", done, mdone);
      check("idle_idx",  msg_idx, midx);
    end
    if (!reset) begin
      check("rst_addr",  mem_if.mem_addr, 0);
      check("rst_wdata", mem_if.mem_wr_data, 0);
    end
    if (prev_stall) check("stall_addr", mem_if.mem_addr, prev_addr);
    prev_stall = running && !mem_if.mem_gnt;
    prev_addr  = mem_if.mem_addr;
  end

  // One run: start pulse, then wait (bounded) for done.
  task automatic run(input int budget, input bit poke_start, output int cycles, output int busy_cyc);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles   = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy) busy_cyc++;
      if (poke_start) start = (cycles == 20);
    end
    start = 1'b0;
    check("done_reached", done, 1);
  endtask

  logic [7:0] img [30];

  initial begin
    int cyc, bcyc, w;
    logic [15:0] ecw;
    logic [7:0] dir_lo [4] = '{8'h00, 8'hFF, 8'h01, 8'h00};
    logic [7:0] dir_hi [4] = '{8'h00, 8'h07, 8'h00, 8'hFC};
    logic [7:0] exp_lo [4] = '{8'h00, 8'hFF, 8'h0F, 8'h17};
    logic [7:0] exp_hi [4] = '{8'h00, 8'hFF, 8'h00, 8'h81};

    #1;
    check("reset_busy",  busy, 0);
    check("reset_done",  done, 0);
    check("reset_req",   mem_if.mem_req, 0);
    check("reset_wren",  mem_if.mem_wr_en, 0);
    check("reset_addr",  mem_if.mem_addr, 0);
    check("reset_wdata", mem_if.mem_wr_data, 0);
    check("reset_idx",   msg_idx, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed message-0 vectors; later runs start from DONE.
    for (int t = 0; t < 4; t++) begin
      mem_write(SRC_BASE,     dir_lo[t]);
      mem_write(SRC_BASE + 1, dir_hi[t]);
      run(200, 1'b0, cyc, bcyc);
      check($sformatf("dir%0d_cycles", t), cyc, 60);
      check($sformatf("dir%0d_lo", t), mem[DST_BASE],     exp_lo[t]);
      check($sformatf("dir%0d_hi", t), mem[DST_BASE + 1], exp_hi[t]);
    end

    // Random messages with grant held; a start pulse lands mid-run.
    for (int i = 0; i < 2 * NUM_MSG; i++) mem_write(SRC_BASE + i, 8'($urandom));
    run(200, 1'b1, cyc, bcyc);
    check("rand_done_edge", cyc, 60);
    check("rand_busy_cycles", bcyc, 60);
    for (int i = 0; i < NUM_MSG; i++) begin
      ecw = encode({mem[SRC_BASE + 2 * i + 1][2:0], mem[SRC_BASE + 2 * i]});
      check($sformatf("rand_lo%0d", i), mem[DST_BASE + 2 * i],     ecw[7:0]);
      check($sformatf("rand_hi%0d", i), mem[DST_BASE + 2 * i + 1], ecw[15:8]);
    end
    for (int i = 0; i < 2 * NUM_MSG; i++) img[i] = mem[DST_BASE + i];

    // Same messages with a stalling arbiter must give the same image.
    for (int i = 0; i < 2 * NUM_MSG; i++) mem_write(DST_BASE + i, 8'h00);
    gnt_rand = 1'b1;
    run(3000, 1'b0, cyc, bcyc);
    gnt_rand = 1'b0;
    for (int i = 0; i < 2 * NUM_MSG; i++)
      check($sformatf("stall_img%0d", i), mem[DST_BASE + i], img[i]);

    // Reset asserted while message 5 is in WR_HI.
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    w = 0;
    while (!(busy && mem_if.mem_addr == AW'(DST_BASE + 11) && mem_if.mem_wr_en) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("reach_wr_hi5", (w < 100) ? 1 : 0, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy",  busy, 0);
    check("midrst_done",  done, 0);
    check("midrst_req",   mem_if.mem_req, 0);
    check("midrst_wren",  mem_if.mem_wr_en, 0);
    check("midrst_addr",  mem_if.mem_addr, 0);
    check("midrst_wdata", mem_if.mem_wr_data, 0);
    check("midrst_idx",   msg_idx, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_done", done, 0);

    // A fresh run after the abandoned one still completes on time.
    run(200, 1'b0, cyc, bcyc);
    check("rerun_cycles", cyc, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
